// File: rtl/jtkicker_colmix.sv
// Kicker final colour mixer: object/char priority, char LUT and RGB palette PROMs, blanking.
// Optional macro JTKICKER_GFXEN_EN: honour gfx_en layer enables (otherwise both layers forced on).
module jtkicker_colmix #(
    parameter SIMFILE_PAL = "",
    parameter SIMFILE_LUT = ""
)(
    input  logic       rst,
    input  logic       clk,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [3:0] obj_pxl,
    input  logic [7:0] scr_pxl,
    input  logic [1:0] gfx_en,
    input  logic [8:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       prog_en,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    localparam int unsigned OBJW = 4;
    localparam int unsigned SCRW = 8;
    localparam int unsigned IDXW = 5;
    localparam int unsigned RGBW = 8;

    // Init files only matter to simulation models; the PROMs here load through prog_*.
    localparam bit unused_simfiles = |{SIMFILE_PAL, SIMFILE_LUT};

    logic [1:0] gfx_eff;
`ifdef JTKICKER_GFXEN_EN
    assign gfx_eff = gfx_en;
`else
    logic unused_gfx_en;
    assign unused_gfx_en = ^gfx_en;
    assign gfx_eff       = 2'b11;
`endif

    logic [3:0]      lut_mem [256];
    logic [RGBW-1:0] pal_mem [32];
    logic [3:0]      lut_q;
    logic [RGBW-1:0] pal_q;

    logic [OBJW-1:0] s1_obj_q;
    logic [SCRW-1:0] s1_scr_q;
    logic            s1_lhbl_q, s1_lvbl_q;
    logic [IDXW-1:0] s2_idx_q, s2_idx_d;
    logic            s2_lhbl_q, s2_lvbl_q;
    logic [RGBW-1:0] rgb_q, rgb_d;
    logic            lhbl_dly_q, lvbl_dly_q;
    logic            pal_we;

    // Palette writes outside 0..31 are dropped rather than aliased.
    assign pal_we = prog_en && !prog_addr[8] && (prog_addr[7:5] == 3'd0);

    // PROMs: continuous synchronous read, writable at any time, never reset.
    always_ff @(posedge clk) begin
        if (prog_en && prog_addr[8]) begin
            lut_mem[prog_addr[7:0]] <= prog_data[3:0];
        end
        if (pal_we) begin
            pal_mem[prog_addr[4:0]] <= prog_data;
        end
        lut_q <= lut_mem[s1_scr_q];
        pal_q <= pal_mem[s2_idx_q];
    end

    // Objects always win when opaque; char LUT value 0 is the backdrop entry.
    always_comb begin
        s2_idx_d = IDXW'(0);
        rgb_d    = RGBW'(0);
        if ((s1_obj_q != 4'd0) && gfx_eff[1]) begin
            s2_idx_d = {1'b1, s1_obj_q};
        end else if (gfx_eff[0]) begin
            s2_idx_d = {1'b0, lut_q};
        end
        if (s2_lhbl_q && s2_lvbl_q) begin
            rgb_d = pal_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_obj_q   <= '0;
            s1_scr_q   <= '0;
            s1_lhbl_q  <= 1'b0;
            s1_lvbl_q  <= 1'b0;
            s2_idx_q   <= '0;
            s2_lhbl_q  <= 1'b0;
            s2_lvbl_q  <= 1'b0;
            rgb_q      <= '0;
            lhbl_dly_q <= 1'b0;
            lvbl_dly_q <= 1'b0;
        end else if (pxl_cen) begin
            s1_obj_q   <= obj_pxl;
            s1_scr_q   <= scr_pxl;
            s1_lhbl_q  <= LHBL;
            s1_lvbl_q  <= LVBL;
            s2_idx_q   <= s2_idx_d;
            s2_lhbl_q  <= s1_lhbl_q;
            s2_lvbl_q  <= s1_lvbl_q;
            rgb_q      <= rgb_d;
            lhbl_dly_q <= s2_lhbl_q;
            lvbl_dly_q <= s2_lvbl_q;
        end
    end

    assign red      = rgb_q[2:0];
    assign green    = rgb_q[5:3];
    assign blue     = rgb_q[7:6];
    assign LHBL_dly = lhbl_dly_q;
    assign LVBL_dly = lvbl_dly_q;

endmodule

// File: tb/tb_jtkicker_colmix.sv
// Directed bench for jtkicker_colmix: priority, LUT/palette mapping, blanking, PROM writes, reset.
// Expected RGB is written as the palette byte {blue,green,red}.
module tb_jtkicker_colmix;

    logic       rst, clk, pxl_cen, LHBL, LVBL, prog_en;
    logic [3:0] obj_pxl;
    logic [7:0] scr_pxl, prog_data;
    logic [1:0] gfx_en;
    logic [8:0] prog_addr;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic       LHBL_dly, LVBL_dly;

    int errors = 0;
    int checks = 0;

    jtkicker_colmix dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .obj_pxl(obj_pxl), .scr_pxl(scr_pxl), .gfx_en(gfx_en),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk) pxl_cen = 1'b1;
        @(negedge clk) pxl_cen = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick3();
        tick(); tick(); tick();
    endtask

    task automatic prog(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_addr = a; prog_data = d; prog_en = 1'b1;
        @(negedge clk) prog_en = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] exp_rgb,
                         input logic exp_lh, input logic exp_lv);
        logic [9:0] obs, exp;
        obs = {blue, green, red, LHBL_dly, LVBL_dly};
        exp = {exp_rgb, exp_lh, exp_lv};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {bgr,lh,lv}=%h required=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0;
        obj_pxl = 4'd0; scr_pxl = 8'd0; gfx_en = 2'b11;
        prog_addr = 9'd0; prog_data = 8'd0; prog_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // PROM image used by every step below
        prog(9'h013, 8'hA5);
        prog(9'h007, 8'h3C);
        prog(9'h000, 8'h12);
        prog(9'h142, 8'h07);
        prog(9'h110, 8'h00);
        prog(9'h100, 8'h00);

        // Opaque object over char
        obj_pxl = 4'd3; scr_pxl = 8'h42; LHBL = 1'b1; LVBL = 1'b1;
        tick(); tick();
        check("a_latency", 8'h00, 1'b0, 1'b0);
        tick();
        check("a_obj", 8'hA5, 1'b1, 1'b1);

        // Transparent object: char 0x42 -> LUT 7 -> palette 7
        obj_pxl = 4'd0;
        tick();
        check("b_hold", 8'hA5, 1'b1, 1'b1);
        tick(); tick();
        check("b_char", 8'h3C, 1'b1, 1'b1);

        // Single blanked pixel
        LHBL = 1'b0; tick();
        LHBL = 1'b1; tick();
        check("c_pre", 8'h3C, 1'b1, 1'b1);
        tick();
        check("c_blank", 8'h00, 1'b0, 1'b1);
        tick();
        check("c_post", 8'h3C, 1'b1, 1'b1);

        // Char LUT value 0 selects backdrop
        scr_pxl = 8'h10; tick3();
        check("d_backdrop", 8'h12, 1'b1, 1'b1);

        // Layer enables
        scr_pxl = 8'h42; obj_pxl = 4'd3;
`ifdef JTKICKER_GFXEN_EN
        gfx_en = 2'b01; tick3();
        check("e_obj_off", 8'h3C, 1'b1, 1'b1);
        gfx_en = 2'b00; tick3();
        check("e_all_off", 8'h12, 1'b1, 1'b1);
`else
        gfx_en = 2'b00; tick3();
        check("e_gfx_ignored", 8'hA5, 1'b1, 1'b1);
`endif
        gfx_en = 2'b11;

        // Palette write during active video
        obj_pxl = 4'd0; tick3();
        check("f_before", 8'h3C, 1'b1, 1'b1);
        prog(9'h007, 8'hFF); tick3();
        check("f_written", 8'hFF, 1'b1, 1'b1);
        prog(9'h0E7, 8'h00); tick3();
        check("f_no_alias", 8'hFF, 1'b1, 1'b1);

        // pxl_cen low: pipeline frozen, PROM load still lands
        obj_pxl = 4'd3;
        repeat (10) @(negedge clk);
        check("g_freeze", 8'hFF, 1'b1, 1'b1);
        prog(9'h007, 8'h3C);
        repeat (4) @(negedge clk);
        check("g_freeze_prog", 8'hFF, 1'b1, 1'b1);
        obj_pxl = 4'd0; tick3();
        check("g_after_prog", 8'h3C, 1'b1, 1'b1);

        // Asynchronous reset mid-line
        obj_pxl = 4'd3;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("h_async_rst", 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        check("h_out1", 8'h00, 1'b0, 1'b0);
        tick();
        check("h_out2", 8'h00, 1'b0, 1'b0);
        tick();
        check("h_out3", 8'hA5, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
